// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Optional bne support is enabled by defining MC_BNE_EN.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // What the FSM asks of the ALU decoder: fixed add/sub, or decode funct fields.
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU operation decode from FSM request and funct fields.
module alu_decoder
  import multicycle_control_pkg::*;
#(
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic [1:0]               alu_op_i,
  input  logic                     op5_i,
  input  logic [2:0]               funct3_i,
  input  logic                     funct7b5_i,
  output logic [ALUCTRL_WIDTH-1:0] alu_ctrl_o
);

  logic [2:0] ctrl;

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  ctrl = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD; // only R-type subtracts
          3'b010:  ctrl = ALU_SLT;
          3'b110:  ctrl = ALU_OR;
          3'b111:  ctrl = ALU_AND;
          default: ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = ALUCTRL_WIDTH'(ctrl);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with retired counter and sticky trap flag.
// Define MC_BNE_EN to execute funct3=001 branches as bne instead of trapping.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_WIDTH     = 16,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               op,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     Zero,
  input  logic                     mem_ready,
  output logic                     PCWrite,
  output logic                     AdrSrc,
  output logic                     MemWrite,
  output logic                     IRWrite,
  output logic                     RegWrite,
  output logic [1:0]               ResultSrc,
  output logic [1:0]               ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [1:0]               immSrc,
  output logic [ALUCTRL_WIDTH-1:0] ALUControl,
  output logic                     trap,
  output logic [CNT_WIDTH-1:0]     retired
);

  state_e                 state_q, state_d;
  logic                   trap_q;
  logic [CNT_WIDTH-1:0]   retired_q;
  logic                   pcw, mw, irw, rw;
  logic [1:0]             alu_op;
  logic                   br_legal, br_take;

`ifdef MC_BNE_EN
  assign br_legal = 1'b1;
  assign br_take  = (funct3 == 3'b001) ? ~Zero : Zero;
`else
  assign br_legal = (funct3 != 3'b001);
  assign br_take  = Zero;
`endif

  always_comb begin
    state_d   = state_q;
    pcw       = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        pcw       = mem_ready;
        irw       = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = br_legal ? S_BEQ : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        pcw     = br_take;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw     = 1'b1;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) trap_q <= 1'b1;
      if (state_d == S_FETCH && state_q != S_FETCH) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  alu_decoder #(.ALUCTRL_WIDTH(ALUCTRL_WIDTH)) u_alu_dec (
    .alu_op_i   (alu_op),
    .op5_i      (op[5]),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (ALUControl)
  );

  // Strobes are gated by reset itself so nothing writes while rst is low.
  assign PCWrite  = pcw & rst;
  assign IRWrite  = irw & rst;
  assign MemWrite = mw & rst;
  assign RegWrite = rw & rst;
  assign immSrc   = imm_src(op);
  assign trap     = trap_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control (default and 4-bit counter builds).
module tb_multicycle_control;

  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] op = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b1;

  logic pcw, adr, mw, irw, rw, trp;
  logic [1:0] res, sa, sb, imm;
  logic [2:0] alu;
  logic [15:0] ret16;
  logic pcw4, adr4, mw4, irw4, rw4, trp4;
  logic [1:0] res4, sa4, sb4, imm4;
  logic [2:0] alu4;
  logic [3:0] ret4;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw),
    .RegWrite(rw), .ResultSrc(res), .ALUSrcA(sa), .ALUSrcB(sb), .immSrc(imm),
    .ALUControl(alu), .trap(trp), .retired(ret16));

  multicycle_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pcw4), .AdrSrc(adr4), .MemWrite(mw4), .IRWrite(irw4),
    .RegWrite(rw4), .ResultSrc(res4), .ALUSrcA(sa4), .ALUSrcB(sb4), .immSrc(imm4),
    .ALUControl(alu4), .trap(trp4), .retired(ret4));

  always #5 clk = ~clk;

  logic [16:0] vec, vec4;
  assign vec  = {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, trp};
  assign vec4 = {pcw4, adr4, mw4, irw4, rw4, res4, sa4, sb4, imm4, alu4, trp4};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                         II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  int errors = 0, checks = 0;

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z, rdy;
    logic [16:0] exp;
    int          ret;
  } vec_t;
  vec_t tbl[$];

  // Expected output word, one field per port in vec order.
  function automatic logic [16:0] ex(input logic p, a, m, i, r, input logic [1:0] rs, xa, xb,
                                     im, input logic [2:0] al, input logic t);
    return {p, a, m, i, r, rs, xa, xb, im, al, t};
  endfunction
  function automatic logic [16:0] F(input logic rdy, input logic [1:0] im);
    return ex(rdy, 0, 0, rdy, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0);
  endfunction
  function automatic logic [16:0] D(input logic [1:0] im);
    return ex(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0);
  endfunction
  function automatic logic [16:0] WB(input logic [1:0] im);
    return ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0);
  endfunction
  function automatic logic [16:0] BRX(input logic p);
    return ex(p, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic addv(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input logic [16:0] e, input int r);
    vec_t v;
    v.nm = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = e; v.ret = r;
    tbl.push_back(v);
  endtask

  // ALU-class instruction: FETCH, DECODE, EXECR/EXECI, ALUWB.
  task automatic alu_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] al, input int r);
    logic [16:0] xe;
    xe = (o == RR) ? ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, al, 0)
                   : ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, al, 0);
    addv({nm, ".F"}, o, f3, f7, 0, 1, F(1, 2'b00), r);
    addv({nm, ".D"}, o, f3, f7, 0, 1, D(2'b00), r);
    addv({nm, ".X"}, o, f3, f7, 0, 1, xe, r);
    addv({nm, ".WB"}, o, f3, f7, 0, 1, WB(2'b00), r);
  endtask

  // Entered at a negedge; checks mid-cycle, leaves at the next negedge.
  task automatic run_tbl();
    foreach (tbl[k]) begin
      op = tbl[k].op; funct3 = tbl[k].f3; funct7b5 = tbl[k].f7;
      Zero = tbl[k].z; mem_ready = tbl[k].rdy;
      #1;
      chk({tbl[k].nm, ".vec"}, 32'(vec), 32'(tbl[k].exp));
      chk({tbl[k].nm, ".vec4"}, 32'(vec4), 32'(tbl[k].exp));
      chk({tbl[k].nm, ".ret"}, 32'(ret16), 32'(tbl[k].ret));
      chk({tbl[k].nm, ".ret4"}, 32'(ret4), 32'(tbl[k].ret % 16));
      @(negedge clk);
    end
    tbl.delete();
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0; mem_ready = 1'b1; op = II; funct3 = 3'b000; Zero = 1'b1;
    #1;
    chk({nm, ".vec"}, 32'(vec), 32'(F(0, 2'b00)));
    chk({nm, ".ret"}, 32'(ret16), 32'd0);
    @(negedge clk);
    chk({nm, ".hold"}, 32'(vec), 32'(F(0, 2'b00)));
    chk({nm, ".ret4"}, 32'(ret4), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset("rst0");

    alu_instr("addi", II, 3'b000, 0, 3'b000, 0);
    addv("fetch.wait", II, 3'b000, 0, 0, 0, F(0, 2'b00), 1);
    alu_instr("sub",  RR, 3'b000, 1, 3'b001, 1);
    alu_instr("and",  RR, 3'b111, 0, 3'b010, 2);
    alu_instr("addi7", II, 3'b000, 1, 3'b000, 3);
    alu_instr("or",   RR, 3'b110, 0, 3'b011, 4);
    alu_instr("slti", II, 3'b010, 0, 3'b101, 5);
    alu_instr("xori", II, 3'b100, 0, 3'b000, 6);
    addv("lw.F",  LW, 3'b010, 0, 0, 1, F(1, 2'b00), 7);
    addv("lw.D",  LW, 3'b010, 0, 0, 1, D(2'b00), 7);
    addv("lw.MA", LW, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), 7);
    addv("lw.MR0", LW, 3'b010, 0, 0, 0, ex(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), 7);
    addv("lw.MR1", LW, 3'b010, 0, 0, 1, ex(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), 7);
    addv("lw.WB", LW, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0), 7);
    addv("sw.F",  SW, 3'b010, 0, 0, 1, F(1, 2'b01), 8);
    addv("sw.D",  SW, 3'b010, 0, 0, 1, D(2'b01), 8);
    addv("sw.MA", SW, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0), 8);
    for (int i = 0; i < 4; i++)
      addv($sformatf("sw.MW%0d", i), SW, 3'b010, 0, 0, (i == 3),
           ex(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0), 8);
    addv("beq1.F", BR, 3'b000, 0, 1, 1, F(1, 2'b10), 9);
    addv("beq1.D", BR, 3'b000, 0, 1, 1, D(2'b10), 9);
    addv("beq1.B", BR, 3'b000, 0, 1, 1, BRX(1), 9);
    addv("beq0.F", BR, 3'b000, 0, 0, 1, F(1, 2'b10), 10);
    addv("beq0.D", BR, 3'b000, 0, 0, 1, D(2'b10), 10);
    addv("beq0.B", BR, 3'b000, 0, 0, 1, BRX(0), 10);
    addv("jal.F", JL, 3'b000, 0, 0, 1, F(1, 2'b11), 11);
    addv("jal.D", JL, 3'b000, 0, 0, 1, D(2'b11), 11);
    addv("jal.J", JL, 3'b000, 0, 0, 1, ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0), 11);
    addv("jal.WB", JL, 3'b000, 0, 0, 1, WB(2'b11), 11);
    addv("fetch.end", II, 3'b000, 0, 0, 0, F(0, 2'b00), 12);
`ifdef MC_BNE_EN
    addv("bne0.F", BR, 3'b001, 0, 0, 1, F(1, 2'b10), 12);
    addv("bne0.D", BR, 3'b001, 0, 0, 1, D(2'b10), 12);
    addv("bne0.B", BR, 3'b001, 0, 0, 1, BRX(1), 12);
    addv("bne1.F", BR, 3'b001, 0, 1, 1, F(1, 2'b10), 13);
    addv("bne1.D", BR, 3'b001, 0, 1, 1, D(2'b10), 13);
    addv("bne1.B", BR, 3'b001, 0, 1, 1, BRX(0), 13);
    addv("bne.end", II, 3'b000, 0, 0, 0, F(0, 2'b00), 14);
`else
    addv("bne.F", BR, 3'b001, 0, 0, 1, F(1, 2'b10), 12);
    addv("bne.D", BR, 3'b001, 0, 0, 1, D(2'b10), 12);
    addv("bne.T", BR, 3'b001, 0, 0, 1, ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 1), 12);
`endif
    run_tbl();

    // Illegal opcode: trap sticks for 10 cycles with every strobe low.
    do_reset("rst1");
    alu_instr("pre", II, 3'b000, 0, 3'b000, 0);
    addv("bad.F", BAD, 3'b000, 0, 1, 1, F(1, 2'b00), 1);
    addv("bad.D", BAD, 3'b000, 0, 1, 1, D(2'b00), 1);
    for (int i = 0; i < 10; i++)
      addv($sformatf("trap%0d", i), BAD, 3'b000, 1, 1, 1,
           ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1), 1);
    run_tbl();
    do_reset("rst2");

    // Reset in MEMREAD aborts the load with no register write.
    addv("lwr.F",  LW, 3'b010, 0, 0, 1, F(1, 2'b00), 0);
    addv("lwr.D",  LW, 3'b010, 0, 0, 1, D(2'b00), 0);
    addv("lwr.MA", LW, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), 0);
    addv("lwr.MR", LW, 3'b010, 0, 0, 0, ex(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), 0);
    run_tbl();
    op = LW; mem_ready = 1'b1; rst = 1'b0;
    #1;
    chk("midrst.vec", 32'(vec), 32'(F(0, 2'b00)));
    @(negedge clk);
    chk("midrst.rw", 32'(rw), 32'd0);
    rst = 1'b1;
    addv("after.F", LW, 3'b010, 0, 0, 0, F(0, 2'b00), 0);
    run_tbl();

    // 17 instructions: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) alu_instr($sformatf("w%0d", i), II, 3'b000, 0, 3'b000, i);
    addv("wrap", II, 3'b000, 0, 0, 0, F(0, 2'b00), 17);
    run_tbl();
    chk("wrap.ret4", 32'(ret4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 Parameter ALUCTRL_WIDTH, default 3: width of ALUControl.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 op  in  7  instruction opcode field.
REQ-006 funct3  in  3  instruction funct3 field.
REQ-007 funct7b5  in  1  instruction bit 30.
REQ-008 Zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory handshake; access completes in a cycle with mem_ready=1.
REQ-010 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes and selects.
REQ-011 ResultSrc, ALUSrcA, ALUSrcB, immSrc  out  2 each  datapath mux selects.
REQ-012 ALUControl  out  ALUCTRL_WIDTH  ALU operation.
REQ-013 trap  out  1  sticky illegal-opcode flag.
REQ-014 retired  out  CNT_WIDTH  completed-instruction count.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
REQ-016 Transitions: FETCH->DECODE only when mem_ready=1, else hold; DECODE-> MEMADR (lw 0000011, sw 0100011), EXECR (0110011), EXECI (0010011), BEQ (1100011), JAL (1101111), TRAP (any other op); MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB when mem_ready=1, else hold; MEMWRITE->FETCH when mem_ready=1, else hold; EXECR/EXECI->ALUWB; MEMWB, ALUWB, BEQ->FETCH; JAL->ALUWB; TRAP holds until reset.
REQ-017 Unlisted outputs SHALL be 0 in every state.
REQ-018 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add; IRWrite=PCWrite=mem_ready.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01, add. MEMADR: ALUSrcA=10, ALUSrcB=01, add.
REQ-020 MEMREAD: AdrSrc=1. MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until mem_ready=1. MEMWB: ResultSrc=01, RegWrite=1.
REQ-021 EXECR: ALUSrcA=10, ALUSrcB=00, funct decode. EXECI: ALUSrcA=10, ALUSrcB=01, funct decode. ALUWB: ResultSrc=00, RegWrite=1.
REQ-022 BEQ: ALUSrcA=10, ALUSrcB=00, sub, PCWrite=Zero. JAL: ALUSrcA=01, ALUSrcB=10, add, PCWrite=1.
REQ-023 ALUControl: add=000, sub=001, and=010, or=011, slt=101; funct decode maps funct3 000->add (sub if funct7b5=1 and op[5]=1), 010->slt, 110->or, 111->and, others->add.
REQ-024 immSrc combinational from op in all states: lw/I-type 00, sw 01, beq 10, jal 11, else 00.
REQ-025 retired SHALL increment by 1, wrapping at 2^CNT_WIDTH, on each transition into FETCH from another state.
REQ-026 trap SHALL set on the clock edge entering TRAP and stay 1 until reset; in TRAP all strobes SHALL be 0.

Reset
REQ-027 While rst=0: state=FETCH, retired=0, trap=0, and all strobes (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be forced 0 regardless of mem_ready.
REQ-028 Reset asserted mid-instruction SHALL abort it immediately, with no partial write after the asserting edge.

Configuration
REQ-029 With macro MC_BNE_EN defined, funct3=001 under op 1100011 SHALL give PCWrite=~Zero in BEQ (bne); without it, funct3=001 under op 1100011 SHALL go DECODE->TRAP.

Structure
REQ-030 The shared package SHALL hold the state enum, opcode constants, ALUControl encodings and immSrc encodings.
REQ-031 The ALU decoder SHALL be the sub-module alu_decoder (combinational); the FSM, counter and trap flag reside in multicycle_control.

Verification
REQ-032 addi x2,x0,5 with mem_ready=1 -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 in cycle 4 only; retired 0->1.
REQ-033 sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH; retired increments once.
REQ-034 beq with Zero=1, then Zero=0 -> PCWrite=1, then 0, in BEQ; ALUControl=001 both times.
REQ-035 op=1111111 -> TRAP, trap=1, strobes 0 for 10 cycles; rst pulse -> FETCH, trap=0, retired=0.
REQ-036 CNT_WIDTH=4, 17 addi instructions -> retired reads 1 after wrap.
REQ-037 rst asserted during MEMREAD -> next state FETCH, no RegWrite; both MC_BNE_EN builds run with bne (funct3=001).
